// File: rtl/if_fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline.
// Owns the PC, drives the synchronous instruction SRAM, applies ID-stage
// branch redirects (also those arriving while the PC is stalled), and holds
// the instruction that belongs to ID stable while ID is stalled.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [32:0]        br_bus,
  output logic [32:0]        if_to_id_bus,
  output logic               inst_sram_en,
  output logic [3:0]         inst_sram_wen,
  output logic [31:0]        inst_sram_addr,
  output logic [31:0]        inst_sram_wdata,
  input  logic [31:0]        inst_sram_rdata,
  output logic [31:0]        id_inst,
  output logic               fetch_adel
);

  // Value loaded at reset so that the first increment lands on RESET_PC.
  localparam logic [31:0] PC_RESET_VAL = RESET_PC - 32'd4;

  logic        w_stall_pc;
  logic        w_stall_ifid;
  logic        w_br_e;
  logic [31:0] w_br_addr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_stall_unused;

  logic [31:0] r_pc;
  logic        r_ce;
  logic        r_br_pend;
  logic [31:0] r_pend_addr;
  logic        r_buf_valid;
  logic [31:0] r_inst_buf;

  assign w_stall_pc     = stall[0];
  assign w_stall_ifid   = stall[1];
  assign w_stall_unused = ^stall[STALL_W-1:2];
  assign w_br_e         = br_bus[32];
  assign w_br_addr      = br_bus[31:0];
  assign w_pc_plus4     = r_pc + 32'd4;

  // Next PC selection: live branch beats a redirect saved during a stall,
  // which beats sequential fetch.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (w_br_e) begin
      w_next_pc = w_br_addr;
    end else if (r_br_pend) begin
      w_next_pc = r_pend_addr;
    end
  end

  // PC, fetch-enable and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= PC_RESET_VAL;
      r_ce        <= 1'b0;
      r_br_pend   <= 1'b0;
      r_pend_addr <= '0;
    end else if (!w_stall_pc) begin
      r_pc      <= w_next_pc;
      r_ce      <= 1'b1;
      r_br_pend <= 1'b0;
    end else if (w_br_e) begin
      // Newest redirect seen during the stall wins.
      r_br_pend   <= 1'b1;
      r_pend_addr <= w_br_addr;
    end
  end

  // Instruction hold buffer: on the first stalled IF/ID cycle the SRAM still
  // returns ID's word, so capture it once and keep it until ID is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_valid <= 1'b0;
      r_inst_buf  <= '0;
    end else if (!w_stall_ifid) begin
      r_buf_valid <= 1'b0;
    end else if (!r_buf_valid) begin
      r_buf_valid <= 1'b1;
      r_inst_buf  <= inst_sram_rdata;
    end
  end

  // Output drive: SRAM reads every cycle from the PC register; writes never.
  always_comb begin
    if_to_id_bus    = {r_ce, r_pc};
    inst_sram_en    = r_ce;
    inst_sram_wen   = '0;
    inst_sram_addr  = r_pc;
    inst_sram_wdata = '0;
    id_inst         = r_buf_valid ? r_inst_buf : inst_sram_rdata;
    fetch_adel      = r_ce & (|r_pc[1:0]);
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by a
// randomized run, all compared each cycle against a transaction-level model
// of the fetch address stream and of the word ID should be seeing.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic [32:0] br_bus = '0;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = '0;
  logic [31:0] id_inst;
  logic        fetch_adel;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_pend;
  logic [31:0] m_paddr;
  logic        m_idv;
  logic [31:0] m_idpc;

  if_fetch_unit #(.RESET_PC(RESET_PC), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .if_to_id_bus(if_to_id_bus), .inst_sram_en(inst_sram_en),
    .inst_sram_wen(inst_sram_wen), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_rdata(inst_sram_rdata),
    .id_inst(id_inst), .fetch_adel(fetch_adel)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF ^ (a * 32'd2654435761);
  endfunction

  // Synchronous SRAM: one-cycle read latency, output holds when disabled.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare all outputs mid-cycle, then
  // advance the model at the edge.
  task automatic cyc(input logic r, input logic [5:0] s, input logic be, input logic [31:0] ba);
    logic [31:0] pc_old;
    logic        ce_old;
    rst    = r;
    stall  = s;
    br_bus = {be, ba};
    @(negedge clk);
    check("bus_ce",  {31'd0, if_to_id_bus[32]}, {31'd0, m_ce});
    check("bus_pc",  if_to_id_bus[31:0], m_pc);
    check("en",      {31'd0, inst_sram_en}, {31'd0, m_ce});
    check("addr",    inst_sram_addr, m_pc);
    check("wen",     {28'd0, inst_sram_wen}, 32'd0);
    check("wdata",   inst_sram_wdata, 32'd0);
    check("adel",    {31'd0, fetch_adel}, {31'd0, m_ce & (m_pc[1:0] != 2'b00)});
    if (m_idv) check("id_inst", id_inst, mem(m_idpc));
    @(posedge clk);
    pc_old = m_pc;
    ce_old = m_ce;
    if (r) begin
      m_pc   = RESET_PC - 32'd4;
      m_ce   = 1'b0;
      m_pend = 1'b0;
      m_idv  = 1'b0;
    end else begin
      if (!s[1]) begin
        m_idv  = ce_old;
        m_idpc = pc_old;
      end
      if (!s[0]) begin
        m_pc   = be ? ba : (m_pend ? m_paddr : pc_old + 32'd4);
        m_ce   = 1'b1;
        m_pend = 1'b0;
      end else if (be) begin
        m_pend  = 1'b1;
        m_paddr = ba;
      end
    end
    #1;
  endtask

  initial begin
    logic [5:0]  rs;
    logic        rb;
    logic [31:0] ra;

    m_pc = RESET_PC - 32'd4; m_ce = 1'b0; m_pend = 1'b0; m_paddr = '0;
    m_idv = 1'b0; m_idpc = '0;

    // Reset
    repeat (3) cyc(1'b1, 6'd0, 1'b0, 32'd0);
    check("rst_pc", if_to_id_bus[31:0], 32'hBFBF_FFFC);
    check("rst_en", {31'd0, inst_sram_en}, 32'd0);
    check("rst_passthru", id_inst, inst_sram_rdata);

    // 1: sequential fetch from RESET_PC
    cyc(1'b0, 6'd0, 1'b0, 32'd0);
    check("t1_a0", inst_sram_addr, 32'hBFC0_0000);
    check("t1_ce", {31'd0, if_to_id_bus[32]}, 32'd1);
    cyc(1'b0, 6'd0, 1'b0, 32'd0);
    check("t1_a1", inst_sram_addr, 32'hBFC0_0004);
    cyc(1'b0, 6'd0, 1'b0, 32'd0);
    check("t1_a2", inst_sram_addr, 32'hBFC0_0008);
    repeat (2) cyc(1'b0, 6'd0, 1'b0, 32'd0);
    check("t2_pc", inst_sram_addr, 32'hBFC0_0010);

    // 2: branch; delay slot 0x10 is latched by ID
    cyc(1'b0, 6'd0, 1'b1, 32'hBFC0_0100);
    check("t2_br", inst_sram_addr, 32'hBFC0_0100);
    check("t2_slot", id_inst, mem(32'hBFC0_0010));
    cyc(1'b0, 6'd0, 1'b0, 32'd0);
    check("t2_seq", inst_sram_addr, 32'hBFC0_0104);

    // 3: ID stalled 3 cycles; ID's word (0x100) held throughout
    repeat (3) begin
      cyc(1'b0, 6'd3, 1'b0, 32'd0);
      check("t3_hold", id_inst, mem(32'hBFC0_0100));
    end
    check("t3_pc", inst_sram_addr, 32'hBFC0_0104);
    cyc(1'b0, 6'd0, 1'b0, 32'd0);

    // 4: redirect during stall, applied on release
    cyc(1'b0, 6'd3, 1'b1, 32'hBFC0_0200);
    cyc(1'b0, 6'd3, 1'b0, 32'd0);
    cyc(1'b0, 6'd0, 1'b0, 32'd0);
    check("t4_pend", inst_sram_addr, 32'hBFC0_0200);
    cyc(1'b0, 6'd0, 1'b0, 32'd0);
    check("t4_clear", inst_sram_addr, 32'hBFC0_0204);

    // 5: live branch on release beats pending one
    cyc(1'b0, 6'd3, 1'b1, 32'hBFC0_0200);
    cyc(1'b0, 6'd0, 1'b1, 32'hBFC0_0300);
    check("t5_live", inst_sram_addr, 32'hBFC0_0300);
    cyc(1'b0, 6'd0, 1'b0, 32'd0);
    check("t5_seq", inst_sram_addr, 32'hBFC0_0304);

    // 6: reset mid-stall with pending branch and full buffer
    cyc(1'b0, 6'd3, 1'b1, 32'hBFC0_0400);
    cyc(1'b0, 6'd3, 1'b0, 32'd0);
    cyc(1'b1, 6'd3, 1'b1, 32'hBFC0_0500);
    check("t6_pc", inst_sram_addr, 32'hBFBF_FFFC);
    check("t6_ce", {31'd0, inst_sram_en}, 32'd0);
    check("t6_buf", id_inst, inst_sram_rdata);
    cyc(1'b0, 6'd0, 1'b0, 32'd0);
    check("t6_refetch", inst_sram_addr, 32'hBFC0_0000);
    repeat (2) cyc(1'b0, 6'd0, 1'b0, 32'd0);

    // 7: misaligned target, then wrap-around
    cyc(1'b0, 6'd0, 1'b1, 32'hBFC0_0102);
    check("t7_adel1", {31'd0, fetch_adel}, 32'd1);
    cyc(1'b0, 6'd0, 1'b1, 32'hBFC0_0200);
    check("t7_adel0", {31'd0, fetch_adel}, 32'd0);
    cyc(1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b0, 6'd0, 1'b0, 32'd0);
    check("t7_wrap", inst_sram_addr, 32'h0000_0000);
    cyc(1'b0, 6'd0, 1'b0, 32'd0);

    // Randomized run
    for (int i = 0; i < 600; i++) begin
      rs = 6'($urandom);
      rs[0] = ($urandom_range(0, 2) == 0);
      rs[1] = rs[0] & $urandom_range(0, 1);
      rb = ($urandom_range(0, 3) == 0);
      ra = $urandom;
      if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
      cyc(($urandom_range(0, 63) == 0), rs, rb, ra);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
